mem_arbiter: RTL

- Arbitrates the single shared memory port between two requesters:
  - IFU instruction fetch, read-only.
  - EXU load/store, read/write with byte mask.
- Sits between the core (ifu, exu_top) and the mems block.
- Fixed EXU priority with an anti-starvation counter for IFU.
- One outstanding transaction at a time; back-to-back issue is allowed on the completion cycle.
- Drives the hold request to ctrl while an EXU access is unfinished, and drops stale fetch responses after a jump.

---
 rtl/mem_arbiter_pkg.sv | 10 +
 rtl/arb_starve_cnt.sv | 19 +
 rtl/mem_arbiter.sv | 87 ++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state encoding and defaults shared by the memory arbiter files
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IF = 2'd1,
    ARB_BUSY_EX = 2'd2
  } arb_state_e;
  localparam int STARVE_MAX_DEF = 4;
  localparam int STARVE_W = 4;
endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: saturating count of EXU grants taken while the IFU waits
module arb_starve_cnt
  import mem_arbiter_pkg::*;
#(
  parameter int MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);
  logic [STARVE_W-1:0] cnt_q, cnt_d;
  assign at_max_o = cnt_q == STARVE_W'(MAX);
  always_comb cnt_d = clr_i ? '0 : (inc_i && !at_max_o) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between IFU fetches and EXU loads/stores
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              ex_req_i,
  input  logic              ex_we_i,
  input  logic [ADDR_W-1:0] ex_addr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic [3:0]        ex_wmask_i,
  output logic              ex_gnt_o,
  output logic              ex_rvalid_o,
  output logic [DATA_W-1:0] ex_rdata_o,
  output logic              hold_flag_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_wmask_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);
  arb_state_e state_q, state_d;
  logic drop_pend_q, drop_pend_d, ex_issued_q, ex_issued_d, err_q, err_d;
  logic idle, rsp, rsp_if, rsp_ex, can_issue, ex_elig, sel_if, sel_ex, accept, at_max;
  arb_starve_cnt #(.MAX(STARVE_MAX)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (if_gnt_o | ~if_req_i),
    .inc_i    (ex_gnt_o & if_req_i),
    .at_max_o (at_max)
  );
  // A held ex_req_i counts as a fresh request only once its access completes
  always_comb begin
    idle        = state_q == ARB_IDLE;
    rsp         = mem_rvalid_i & ~idle;
    rsp_if      = rsp & (state_q == ARB_BUSY_IF);
    rsp_ex      = rsp & (state_q == ARB_BUSY_EX);
    can_issue   = rst & (idle | mem_rvalid_i);
    ex_elig     = ex_req_i & (~ex_issued_q | rsp_ex);
    sel_if      = if_req_i & (~ex_elig | at_max);
    mem_req_o   = can_issue & (if_req_i | ex_elig);
    sel_ex      = mem_req_o & ~sel_if;
    accept      = mem_req_o & mem_gnt_i;
    if_gnt_o    = accept & sel_if;
    ex_gnt_o    = accept & ~sel_if;
    mem_we_o    = sel_ex & ex_we_i;
    mem_addr_o  = ~mem_req_o ? '0 : sel_if ? if_addr_i : ex_addr_i;
    mem_wdata_o = sel_ex ? ex_wdata_i : '0;
    mem_wmask_o = sel_ex ? ex_wmask_i : '0;
    ex_rvalid_o = rsp_ex;
    ex_rdata_o  = rsp_ex ? mem_rdata_i : '0;
    if_rvalid_o = rsp_if & ~drop_pend_q & ~if_flush_i;
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    hold_flag_o = rst & ex_req_i & ~ex_rvalid_o;
    state_d     = accept ? (sel_if ? ARB_BUSY_IF : ARB_BUSY_EX) : rsp ? ARB_IDLE : state_q;
    drop_pend_d = (state_q == ARB_BUSY_IF) & ~mem_rvalid_i & (drop_pend_q | if_flush_i);
    ex_issued_d = ex_gnt_o | (ex_issued_q & ~rsp_ex);
    err_d       = err_q | (idle & mem_rvalid_i);
  end
  assign err_o = err_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q     <= ARB_IDLE;
      drop_pend_q <= 1'b0;
      ex_issued_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      drop_pend_q <= drop_pend_d;
      ex_issued_q <= ex_issued_d;
      err_q       <= err_d;
    end
endmodule
